// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hit/block resolution, health and block meters,
// optional hit-stop freeze and round-end/winner tracking for a two-player fighter.
// Optional feature macro: HITSTOP_EN (adds the HITSTOP freeze state and the
// HITSTOP_FRAMES parameter; without it freeze is tied low).
module combat_resolver #(
  parameter int CHAR_W       = 128,
  parameter int HURT_X1      = 44,
  parameter int HURT_X2      = 84,
  parameter int HIT_X1       = 84,
  parameter int HIT_X2       = 122,
  parameter int HP_MAX       = 100,
  parameter int HP_W         = 7,
  parameter int DMG          = 10,
  parameter int BLK_MAX      = 3,
  parameter int BLK_W        = 2,
  parameter int REGEN_FRAMES = 120
`ifdef HITSTOP_EN
  ,
  parameter int HITSTOP_FRAMES = 6
`endif
) (
  input  logic             clk_game,
  input  logic             reset,
  input  logic             restart,
  input  logic [3:0]       state_p1,
  input  logic [3:0]       state_p2,
  input  logic [9:0]       char1_x,
  input  logic [9:0]       char2_x,
  output logic [HP_W-1:0]  health_p1,
  output logic [HP_W-1:0]  health_p2,
  output logic [BLK_W-1:0] block_p1,
  output logic [BLK_W-1:0] block_p2,
  output logic             hit_p1,
  output logic             hit_p2,
  output logic             blocked_p1,
  output logic             blocked_p2,
  output logic             freeze,
  output logic             round_over,
  output logic [1:0]       winner
);

  localparam int RG_W = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  DMG_V    = HP_W'(DMG);
  localparam logic [HP_W-1:0]  HP_ZERO  = {HP_W{1'b0}};
  localparam logic [BLK_W-1:0] BLK_FULL = BLK_W'(BLK_MAX);
  localparam logic [BLK_W-1:0] BLK_ZERO = {BLK_W{1'b0}};
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
  localparam logic [RG_W-1:0]  RG_LAST  = RG_W'(REGEN_FRAMES - 1);
  localparam logic [RG_W-1:0]  RG_ZERO  = {RG_W{1'b0}};
  localparam logic [RG_W-1:0]  RG_ONE   = RG_W'(1);

`ifdef HITSTOP_EN
  localparam int HS_W = (HITSTOP_FRAMES > 1) ? $clog2(HITSTOP_FRAMES) : 1;
  localparam logic [HS_W-1:0] HS_LAST = HS_W'(HITSTOP_FRAMES - 1);
  localparam logic [HS_W-1:0] HS_ZERO = {HS_W{1'b0}};
  localparam logic [HS_W-1:0] HS_ONE  = HS_W'(1);
`endif

  typedef enum logic [1:0] {
    ST_FIGHT      = 2'd0,
`ifdef HITSTOP_EN
    ST_HITSTOP    = 2'd1,
`endif
    ST_ROUND_OVER = 2'd2
  } state_t;

  state_t          state;
  logic [RG_W-1:0] regen_cnt;
  logic            latch_p1;
  logic            latch_p2;
`ifdef HITSTOP_EN
  logic [HS_W-1:0] hs_cnt;
`endif

  // Screen-space boxes, widened to 11 bits so x + offset never wraps.
  logic [10:0] x1e, x2e;
  logic [10:0] p1_hurt_lo, p1_hurt_hi, p1_hit_lo, p1_hit_hi;
  logic [10:0] p2_hurt_lo, p2_hurt_hi, p2_hit_lo, p2_hit_hi;

  assign x1e        = {1'b0, char1_x};
  assign x2e        = {1'b0, char2_x};
  assign p1_hurt_lo = x1e + 11'(HURT_X1);
  assign p1_hurt_hi = x1e + 11'(HURT_X2);
  assign p1_hit_lo  = x1e + 11'(HIT_X1);
  assign p1_hit_hi  = x1e + 11'(HIT_X2);
  // P2 faces left, so its boxes are mirrored about the sprite width.
  assign p2_hurt_lo = x2e + 11'(CHAR_W - HURT_X2);
  assign p2_hurt_hi = x2e + 11'(CHAR_W - HURT_X1);
  assign p2_hit_lo  = x2e + 11'(CHAR_W - HIT_X2);
  assign p2_hit_hi  = x2e + 11'(CHAR_W - HIT_X1);

  function automatic logic overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                   input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

  function automatic logic [HP_W-1:0] take_damage(input logic [HP_W-1:0] hp);
    return (hp >= DMG_V) ? (hp - DMG_V) : HP_ZERO;
  endfunction

  logic            atk_p1, atk_p2;
  logic            lands_on_p1, lands_on_p2;
  logic            blk_ok_p1, blk_ok_p2;
  logic            dmg_p1, dmg_p2;
  logic            regen_wrap;
  logic [HP_W-1:0]  hp1_n, hp2_n;
  logic [BLK_W-1:0] blk1_n, blk2_n;
  logic            latch_p1_n, latch_p2_n;
  logic            ko;

  // Hit detection and post-update meter values for the current FIGHT frame.
  always_comb begin
    atk_p1      = (state_p1 == 4'b0100) || (state_p1 == 4'b0111);
    atk_p2      = (state_p2 == 4'b0100) || (state_p2 == 4'b0111);
    lands_on_p2 = (state == ST_FIGHT) && atk_p1 && !latch_p1 &&
                  overlap(p1_hit_lo, p1_hit_hi, p2_hurt_lo, p2_hurt_hi);
    lands_on_p1 = (state == ST_FIGHT) && atk_p2 && !latch_p2 &&
                  overlap(p2_hit_lo, p2_hit_hi, p1_hurt_lo, p1_hurt_hi);
    blk_ok_p1   = lands_on_p1 && (state_p1 == 4'b0001) && (block_p1 != BLK_ZERO);
    blk_ok_p2   = lands_on_p2 && (state_p2 == 4'b0010) && (block_p2 != BLK_ZERO);
    dmg_p1      = lands_on_p1 && !blk_ok_p1;
    dmg_p2      = lands_on_p2 && !blk_ok_p2;
    regen_wrap  = (state == ST_FIGHT) && (regen_cnt == RG_LAST);

    hp1_n = dmg_p1 ? take_damage(health_p1) : health_p1;
    hp2_n = dmg_p2 ? take_damage(health_p2) : health_p2;

    // A meter spent this frame does not also regenerate this frame.
    if (blk_ok_p1) begin
      blk1_n = block_p1 - BLK_ONE;
    end else if (regen_wrap && (block_p1 < BLK_FULL)) begin
      blk1_n = block_p1 + BLK_ONE;
    end else begin
      blk1_n = block_p1;
    end
    if (blk_ok_p2) begin
      blk2_n = block_p2 - BLK_ONE;
    end else if (regen_wrap && (block_p2 < BLK_FULL)) begin
      blk2_n = block_p2 + BLK_ONE;
    end else begin
      blk2_n = block_p2;
    end

    // Latch arms on a landed hit, disarms once the attack window ends.
    if (lands_on_p2) begin
      latch_p1_n = 1'b1;
    end else if (!atk_p1) begin
      latch_p1_n = 1'b0;
    end else begin
      latch_p1_n = latch_p1;
    end
    if (lands_on_p1) begin
      latch_p2_n = 1'b1;
    end else if (!atk_p2) begin
      latch_p2_n = 1'b0;
    end else begin
      latch_p2_n = latch_p2;
    end

    ko = (hp1_n == HP_ZERO) || (hp2_n == HP_ZERO);
  end

  // Round FSM with registered meters, pulses, freeze, round_over and winner.
  always_ff @(posedge clk_game) begin
    if (reset || ((state == ST_ROUND_OVER) && restart)) begin
      state      <= ST_FIGHT;
      health_p1  <= HP_FULL;
      health_p2  <= HP_FULL;
      block_p1   <= BLK_FULL;
      block_p2   <= BLK_FULL;
      hit_p1     <= 1'b0;
      hit_p2     <= 1'b0;
      blocked_p1 <= 1'b0;
      blocked_p2 <= 1'b0;
      round_over <= 1'b0;
      winner     <= 2'b00;
      regen_cnt  <= RG_ZERO;
      latch_p1   <= 1'b0;
      latch_p2   <= 1'b0;
`ifdef HITSTOP_EN
      freeze     <= 1'b0;
      hs_cnt     <= HS_ZERO;
`endif
    end else begin
      hit_p1     <= 1'b0;
      hit_p2     <= 1'b0;
      blocked_p1 <= 1'b0;
      blocked_p2 <= 1'b0;
      case (state)
        ST_FIGHT: begin
          health_p1  <= hp1_n;
          health_p2  <= hp2_n;
          block_p1   <= blk1_n;
          block_p2   <= blk2_n;
          hit_p1     <= dmg_p1;
          hit_p2     <= dmg_p2;
          blocked_p1 <= blk_ok_p1;
          blocked_p2 <= blk_ok_p2;
          latch_p1   <= latch_p1_n;
          latch_p2   <= latch_p2_n;
          regen_cnt  <= regen_wrap ? RG_ZERO : (regen_cnt + RG_ONE);
          if (ko) begin
            state      <= ST_ROUND_OVER;
            round_over <= 1'b1;
            winner     <= {hp1_n == HP_ZERO, hp2_n == HP_ZERO};
`ifdef HITSTOP_EN
          end else if (lands_on_p1 || lands_on_p2) begin
            state  <= ST_HITSTOP;
            freeze <= 1'b1;
            hs_cnt <= HS_LAST;
`endif
          end else begin
            state <= ST_FIGHT;
          end
        end
`ifdef HITSTOP_EN
        ST_HITSTOP: begin
          if (hs_cnt == HS_ZERO) begin
            state  <= ST_FIGHT;
            freeze <= 1'b0;
          end else begin
            hs_cnt <= hs_cnt - HS_ONE;
          end
        end
`endif
        ST_ROUND_OVER: begin
          state <= ST_ROUND_OVER;
        end
        default: begin
          state <= ST_FIGHT;
        end
      endcase
    end
  end

`ifndef HITSTOP_EN
  assign freeze = 1'b0;
`endif

endmodule

// File: tb/tb_combat_resolver.sv
// Scoreboard bench for combat_resolver: a frame-level reference model pushes the
// expected outputs of every frame; a monitor pops and compares after each edge.
module tb_combat_resolver;

  localparam int CHAR_W = 128, HURT_X1 = 44, HURT_X2 = 84, HIT_X1 = 84, HIT_X2 = 122;
  localparam int HP_MAX = 100, DMG = 10, BLK_MAX = 3, REGEN_FRAMES = 120, HITSTOP_FRAMES = 6;
`ifdef HITSTOP_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       clk_game = 1'b0;
  logic       reset, restart;
  logic [3:0] state_p1, state_p2;
  logic [9:0] char1_x, char2_x;
  logic [6:0] health_p1, health_p2;
  logic [1:0] block_p1, block_p2;
  logic       hit_p1, hit_p2, blocked_p1, blocked_p2, freeze, round_over;
  logic [1:0] winner;

  combat_resolver dut (
    .clk_game(clk_game), .reset(reset), .restart(restart),
    .state_p1(state_p1), .state_p2(state_p2), .char1_x(char1_x), .char2_x(char2_x),
    .health_p1(health_p1), .health_p2(health_p2), .block_p1(block_p1), .block_p2(block_p2),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .blocked_p1(blocked_p1), .blocked_p2(blocked_p2),
    .freeze(freeze), .round_over(round_over), .winner(winner)
  );

  always #5 clk_game = ~clk_game;

  typedef struct packed {
    logic [6:0] hp1, hp2;
    logic [1:0] b1, b2;
    logic       hit1, hit2, bl1, bl2, frz, ro;
    logic [1:0] win;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 = fighting, 1 = frozen, 2 = round finished.
  int m_hp[2], m_blk[2], m_mode, m_hs, m_rg, m_win;
  bit m_lat[2];

  task automatic model_init();
    m_hp[0] = HP_MAX; m_hp[1] = HP_MAX; m_blk[0] = BLK_MAX; m_blk[1] = BLK_MAX;
    m_mode = 0; m_hs = 0; m_rg = 0; m_win = 0; m_lat[0] = 1'b0; m_lat[1] = 1'b0;
  endtask

  task automatic model_step();
    int st[2], blk_code[2], hit_lo[2], hit_hi[2], hurt_lo[2], hurt_hi[2];
    bit atk[2], lands[2], e_hit[2], e_bl[2], dec[2], wrap;
    obs_t e;
    st[0] = int'(state_p1); st[1] = int'(state_p2);
    blk_code[0] = 1; blk_code[1] = 2;
    hurt_lo[0] = int'(char1_x) + HURT_X1;          hurt_hi[0] = int'(char1_x) + HURT_X2;
    hit_lo[0]  = int'(char1_x) + HIT_X1;           hit_hi[0]  = int'(char1_x) + HIT_X2;
    hurt_lo[1] = int'(char2_x) + CHAR_W - HURT_X2; hurt_hi[1] = int'(char2_x) + CHAR_W - HURT_X1;
    hit_lo[1]  = int'(char2_x) + CHAR_W - HIT_X2;  hit_hi[1]  = int'(char2_x) + CHAR_W - HIT_X1;
    for (int p = 0; p < 2; p++) begin
      e_hit[p] = 1'b0; e_bl[p] = 1'b0; dec[p] = 1'b0; lands[p] = 1'b0; atk[p] = 1'b0;
    end
    if (reset) begin
      model_init();
    end else if (m_mode == 2) begin
      if (restart) model_init();
    end else if (m_mode == 1) begin
      if (m_hs == 0) m_mode = 0;
      else m_hs = m_hs - 1;
    end else begin
      for (int a = 0; a < 2; a++) begin
        atk[a]   = (st[a] == 4) || (st[a] == 7);
        lands[a] = atk[a] && !m_lat[a] && (hit_lo[a] < hurt_hi[1-a]) && (hurt_lo[1-a] < hit_hi[a]);
      end
      wrap = (m_rg == REGEN_FRAMES - 1);
      m_rg = wrap ? 0 : m_rg + 1;
      for (int a = 0; a < 2; a++) begin
        if (lands[a]) begin
          m_lat[a] = 1'b1;
          if (st[1-a] == blk_code[1-a] && m_blk[1-a] > 0) begin
            m_blk[1-a] = m_blk[1-a] - 1; dec[1-a] = 1'b1; e_bl[1-a] = 1'b1;
          end else begin
            m_hp[1-a] = (m_hp[1-a] >= DMG) ? m_hp[1-a] - DMG : 0; e_hit[1-a] = 1'b1;
          end
        end else if (!atk[a]) begin
          m_lat[a] = 1'b0;
        end
      end
      if (wrap)
        for (int p = 0; p < 2; p++)
          if (!dec[p] && m_blk[p] < BLK_MAX) m_blk[p] = m_blk[p] + 1;
      if (m_hp[0] == 0 || m_hp[1] == 0) begin
        m_mode = 2;
        m_win  = (m_hp[0] == 0 ? 2 : 0) + (m_hp[1] == 0 ? 1 : 0);
      end else if ((lands[0] || lands[1]) && HS_EN) begin
        m_mode = 1; m_hs = HITSTOP_FRAMES - 1;
      end
    end
    e.hp1 = 7'(m_hp[0]); e.hp2 = 7'(m_hp[1]); e.b1 = 2'(m_blk[0]); e.b2 = 2'(m_blk[1]);
    e.hit1 = e_hit[0]; e.hit2 = e_hit[1]; e.bl1 = e_bl[0]; e.bl2 = e_bl[1];
    e.frz = (m_mode == 1); e.ro = (m_mode == 2); e.win = 2'(m_win);
    exp_q.push_back(e);
  endtask

  // Model advances on each frame edge using the inputs it sees there.
  always @(posedge clk_game) model_step();

  // Monitor: pops one expectation per frame and compares against the DUT.
  always @(posedge clk_game) begin
    obs_t g, e;
    #1;
    g = '{health_p1, health_p2, block_p1, block_p2, hit_p1, hit_p2,
          blocked_p1, blocked_p2, freeze, round_over, winner};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL frame t=%0t got hp=%0d/%0d blk=%0d/%0d hit=%b%b blkd=%b%b frz=%b ro=%b win=%b exp hp=%0d/%0d blk=%0d/%0d hit=%b%b blkd=%b%b frz=%b ro=%b win=%b",
                 $time, g.hp1, g.hp2, g.b1, g.b2, g.hit1, g.hit2, g.bl1, g.bl2, g.frz, g.ro, g.win,
                 e.hp1, e.hp2, e.b1, e.b2, e.hit1, e.hit2, e.bl1, e.bl2, e.frz, e.ro, e.win);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_game);
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; state_p1 = 4'd0; state_p2 = 4'd0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int st_tab[7];
    st_tab[0] = 0; st_tab[1] = 1; st_tab[2] = 2; st_tab[3] = 4; st_tab[4] = 7; st_tab[5] = 3; st_tab[6] = 8;
    reset = 1'b1; restart = 1'b0; state_p1 = 4'd0; state_p2 = 4'd0;
    char1_x = 10'd100; char2_x = 10'd150;
    tick(3);
    chk("reset_hp1", health_p1, 100); chk("reset_blk2", block_p2, 3);
    chk("reset_winner", winner, 0);   chk("reset_freeze", freeze, 0);
    reset = 1'b0;

    // Single P1 attack held for three frames lands exactly once.
    state_p1 = 4'b0100; tick(3); state_p1 = 4'd0; tick(10);
    chk("one_hit_hp2", health_p2, 90); chk("one_hit_hp1", health_p1, 100);

    // Out of range: P2 hurtbox starts at 244, P1 hitbox ends at 222.
    do_reset(); char2_x = 10'd200;
    state_p1 = 4'b0100; tick(3); state_p1 = 4'd0; tick(3);
    chk("miss_hp2", health_p2, 100); chk("miss_hp1", health_p1, 100);

    // P2 blocks three attacks, the fourth gets through.
    do_reset(); char2_x = 10'd150; state_p2 = 4'b0010;
    repeat (4) begin state_p1 = 4'b0100; tick(1); state_p1 = 4'd0; tick(10); end
    chk("block_drain_blk2", block_p2, 0); chk("block_drain_hp2", health_p2, 90);

    // Trade: both attack on the same frame.
    do_reset(); state_p1 = 4'b0100; state_p2 = 4'b0100; tick(1);
    state_p1 = 4'd0; state_p2 = 4'd0; tick(10);
    chk("trade_hp1", health_p1, 90); chk("trade_hp2", health_p2, 90);

    // restart outside the finished round is ignored.
    do_reset(); state_p1 = 4'b0111; tick(1); state_p1 = 4'd0;
    restart = 1'b1; tick(1); restart = 1'b0; tick(8);
    chk("restart_ignored_hp2", health_p2, 90);

    // Knock-out and restart.
    do_reset();
    repeat (10) begin state_p1 = 4'b0100; tick(1); state_p1 = 4'd0; tick(8); end
    chk("ko_hp2", health_p2, 0); chk("ko_round_over", round_over, 1); chk("ko_winner", winner, 1);
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("restart_hp1", health_p1, 100); chk("restart_hp2", health_p2, 100);
    chk("restart_blk1", block_p1, 3); chk("restart_winner", winner, 0);

    // Block-meter regen after one spent block.
    do_reset(); state_p1 = 4'b0001; state_p2 = 4'b0100; tick(1);
    state_p1 = 4'd0; state_p2 = 4'd0; tick(100);
    chk("regen_before_wrap", block_p1, 2);
    tick(40); chk("regen_after_wrap", block_p1, 3);
    tick(120); chk("regen_saturated", block_p1, 3);

    // Randomized frames checked only by the scoreboard.
    for (int i = 0; i < 4000; i++) begin
      char1_x  = 10'($urandom_range(0, 880));
      char2_x  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'(int'(char1_x) + $urandom_range(0, 120));
      state_p1 = 4'(st_tab[$urandom_range(0, 6)]);
      state_p2 = 4'(st_tab[$urandom_range(0, 6)]);
      restart  = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0; restart = 1'b0; state_p1 = 4'd0; state_p2 = 4'd0;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
